demux_scheduler: RTL

Round-robin distributor that takes one valid/ready input stream and deals successive words to NUM_ELEM output channels, one channel per word, in cyclic order. It drives one output row at a time: only the selected row carries data and every other row is zero. It adds a one-word holding register and per-channel handshakes, so a shared producer can feed several consumers, such as per-lane TX paths, without combinational ready loops.

---
 rtl/demux_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/demux_scheduler.sv
// demux_scheduler
// Round-robin distributor: deals successive words from one valid/ready input
// stream to NUM_ELEM output channels in cyclic order through a one-word
// holding register. Only the target row of o_o carries data.
//
// Optional feature macro: DEMUX_SCHED_SKIP_EN
//   defined   -> on accept, the word goes to the first ready channel in cyclic
//                order starting at the pointer (busy channels are skipped)
//   undefined -> strict round-robin; no o_ready_i search logic is built
module demux_scheduler #(
  parameter int NUM_ELEM   = 6,
  parameter int ELEM_WIDTH = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [ELEM_WIDTH-1:0]                i_i,
  input  logic                                 i_valid_i,
  output logic                                 i_ready_o,
  output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  o_o,
  output logic [NUM_ELEM-1:0]                  o_valid_o,
  input  logic [NUM_ELEM-1:0]                  o_ready_i,
  output logic [$clog2(NUM_ELEM)-1:0]          tgt_o,
  output logic [$clog2(NUM_ELEM)-1:0]          ptr_o
);

  localparam int IDX_W = $clog2(NUM_ELEM);
  localparam int CW    = IDX_W + 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Next index after v, wrapping explicitly so a non-power-of-two channel
  // count never yields an out-of-range index.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    if (v == IDX_W'(NUM_ELEM - 1)) begin
      r = {IDX_W{1'b0}};
    end else begin
      r = v + IDX_W'(1);
    end
    return r;
  endfunction

  state_t                               state_r, state_nxt_s;
  logic [ELEM_WIDTH-1:0]                data_r, data_nxt_s;
  logic [IDX_W-1:0]                     tgt_r, tgt_nxt_s;
  logic [IDX_W-1:0]                     ptr_r, ptr_nxt_s;
  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  o_mat_r, o_mat_nxt_s;
  logic [NUM_ELEM-1:0]                  o_valid_r, o_valid_nxt_s;
  logic [IDX_W-1:0]                     sel_s;
  logic                                 xfer_s;
  logic                                 accept_s;

  // The held word leaves when its own channel is ready; a new word may enter
  // in the same cycle, and never while flushing.
  assign xfer_s    = (state_r == ST_FULL) && o_ready_i[tgt_r];
  assign i_ready_o = !flush_i && ((state_r == ST_EMPTY) || xfer_s);
  assign accept_s  = i_valid_i && i_ready_o;

`ifdef DEMUX_SCHED_SKIP_EN
  logic [CW-1:0] cand_s;

  // Pick the first ready channel in cyclic order from ptr; fall back to ptr.
  always_comb begin
    sel_s  = ptr_r;
    cand_s = {CW{1'b0}};
    for (int i = NUM_ELEM - 1; i >= 0; i--) begin
      cand_s = {1'b0, ptr_r} + CW'(i);
      if (cand_s >= CW'(NUM_ELEM)) begin
        cand_s = cand_s - CW'(NUM_ELEM);
      end else begin
        cand_s = cand_s;
      end
      if (o_ready_i[cand_s[IDX_W-1:0]]) begin
        sel_s = cand_s[IDX_W-1:0];
      end else begin
        sel_s = sel_s;
      end
    end
  end
`else
  // Strict round-robin: the word always goes to the pointer's channel.
  assign sel_s = ptr_r;
`endif

  // State register: synchronous active-low reset, everything else from next-state logic.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r   <= ST_EMPTY;
      data_r    <= {ELEM_WIDTH{1'b0}};
      tgt_r     <= {IDX_W{1'b0}};
      ptr_r     <= {IDX_W{1'b0}};
      o_mat_r   <= '0;
      o_valid_r <= {NUM_ELEM{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      data_r    <= data_nxt_s;
      tgt_r     <= tgt_nxt_s;
      ptr_r     <= ptr_nxt_s;
      o_mat_r   <= o_mat_nxt_s;
      o_valid_r <= o_valid_nxt_s;
    end
  end

  // Next-state logic: flush drops the held word; accept wins over a plain transfer.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    tgt_nxt_s   = tgt_r;
    ptr_nxt_s   = ptr_r;
    if (flush_i) begin
      state_nxt_s = ST_EMPTY;
      data_nxt_s  = {ELEM_WIDTH{1'b0}};
      tgt_nxt_s   = {IDX_W{1'b0}};
      ptr_nxt_s   = {IDX_W{1'b0}};
    end else if (accept_s) begin
      state_nxt_s = ST_FULL;
      data_nxt_s  = i_i;
      tgt_nxt_s   = sel_s;
      ptr_nxt_s   = wrap_inc(sel_s);
    end else if (xfer_s) begin
      state_nxt_s = ST_EMPTY;
      data_nxt_s  = {ELEM_WIDTH{1'b0}};
      tgt_nxt_s   = {IDX_W{1'b0}};
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode from next state so every output leaves a register.
  always_comb begin
    o_mat_nxt_s   = '0;
    o_valid_nxt_s = {NUM_ELEM{1'b0}};
    for (int k = 0; k < NUM_ELEM; k++) begin
      case (state_nxt_s)
        ST_FULL: begin
          if (tgt_nxt_s == IDX_W'(k)) begin
            o_valid_nxt_s[k] = 1'b1;
            o_mat_nxt_s[k]   = data_nxt_s;
          end else begin
            o_valid_nxt_s[k] = 1'b0;
            o_mat_nxt_s[k]   = {ELEM_WIDTH{1'b0}};
          end
        end
        default: begin
          o_valid_nxt_s[k] = 1'b0;
          o_mat_nxt_s[k]   = {ELEM_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign o_o       = o_mat_r;
  assign o_valid_o = o_valid_r;
  assign tgt_o     = tgt_r;
  assign ptr_o     = ptr_r;

endmodule
